// File: rtl/mips32_fetch_queue.sv
// Instruction-fetch front end: credit-limited word fetch into an in-order
// {IR, NPC} queue, with branch-redirect flush and stop-on-HLT.
module mips32_fetch_queue #(
    parameter int                ADDR_W   = 10,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk1,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_ir,
    output logic [31:0]       if_npc,
    output logic              halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  outs_q, outs_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic              halted_q, halted_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

    logic [31:0]       ir_mem_q   [DEPTH];
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [ADDR_W-1:0] tag_mem_q  [DEPTH];

    logic accept, pop, q_push, is_hlt;

    // Combined queue + in-flight credit guarantees every response a free slot.
    assign imem_req_valid = rst_n && !halted_q && !redirect_valid &&
                            (({1'b0, occ_q} + {1'b0, outs_q}) < (CNT_W+1)'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign if_valid       = (occ_q != '0);
    assign pop            = if_valid && if_ready && !redirect_valid;
    assign is_hlt         = (imem_rsp_data[31:26] == 6'b111111);
    assign halted         = halted_q;
    assign if_ir          = if_valid ? ir_mem_q[head_q] : '0;
    assign if_npc         = if_valid ? (32'(addr_mem_q[head_q]) + 32'd1) : '0;

    always_comb begin
        // NOTE: every next-state signal gets its default first so no path infers a latch.
        pc_d     = pc_q;
        outs_d   = outs_q;
        drop_d   = drop_q;
        occ_d    = occ_q;
        halted_d = halted_q;
        head_d   = head_q;
        tail_d   = tail_q;
        tag_wr_d = tag_wr_q;
        tag_rd_d = tag_rd_q;
        q_push   = 1'b0;

        if (accept) begin
            pc_d     = pc_q + ADDR_W'(1);
            tag_wr_d = tag_wr_q + PTR_W'(1);
        end
        if (imem_rsp_valid) begin
            tag_rd_d = tag_rd_q + PTR_W'(1);
        end
        case ({accept, imem_rsp_valid})
            2'b10:   outs_d = outs_q + CNT_W'(1);
            2'b01:   outs_d = outs_q - CNT_W'(1);
            default: outs_d = outs_q;
        endcase

        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_d     = redirect_pc;
            halted_d = 1'b0;
            occ_d    = '0;
            head_d   = '0;
            tail_d   = '0;
            drop_d   = outs_d;
        end else begin
            if (imem_rsp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CNT_W'(1);
                end else begin
                    q_push = 1'b1;
                    tail_d = tail_q + PTR_W'(1);
                    if (is_hlt) halted_d = 1'b1;
                end
            end
            if (pop) head_d = head_q + PTR_W'(1);
            case ({q_push, pop})
                2'b10:   occ_d = occ_q + CNT_W'(1);
                2'b01:   occ_d = occ_q - CNT_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            outs_q   <= '0;
            drop_q   <= '0;
            occ_q    <= '0;
            halted_q <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
        end else begin
            pc_q     <= pc_d;
            outs_q   <= outs_d;
            drop_q   <= drop_d;
            occ_q    <= occ_d;
            halted_q <= halted_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            tag_wr_q <= tag_wr_d;
            tag_rd_q <= tag_rd_d;
        end
    end

    // NOTE: storage arrays are not reset; outputs are masked by occupancy instead.
    always_ff @(posedge clk1) begin
        if (accept) begin
            tag_mem_q[tag_wr_q] <= pc_q;
        end
        if (q_push) begin
            ir_mem_q[tail_q]   <= imem_rsp_data;
            addr_mem_q[tail_q] <= tag_mem_q[tag_rd_q];
        end
    end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Self-checking bench for mips32_fetch_queue: queue-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_mips32_fetch_queue;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;

    typedef struct { logic [ADDR_W-1:0] addr; int due; } mem_req_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic stale; } fetch_t;
    typedef struct { logic [31:0] ir; logic [31:0] npc; } insn_t;

    logic              clk1 = 1'b0;
    logic              rst_n;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_ir;
    logic [31:0]       if_npc;
    logic              halted;

    mips32_fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk1           (clk1),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_ir          (if_ir),
        .if_npc         (if_npc),
        .halted         (halted)
    );

    always #5 clk1 = ~clk1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int lat      = 1;
    logic              hlt_en   = 1'b0;
    logic [ADDR_W-1:0] hlt_addr = '0;

    mem_req_t          mem_q[$];
    insn_t             got[$];
    logic [ADDR_W-1:0] acc[$];

    // Reference model state: fetch pointer, delivered-instruction queue and
    // in-flight fetch list where redirects simply mark older fetches stale.
    logic [ADDR_W-1:0] m_pc;
    logic              m_halted;
    insn_t             m_fifo[$];
    fetch_t            m_infl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        if (hlt_en && a == hlt_addr) return {6'b111111, 26'(a)};
        return 32'h0000_1000 + 32'(a);
    endfunction

    task automatic m_reset();
        m_pc     = '0;
        m_halted = 1'b0;
        m_fifo.delete();
        m_infl.delete();
    endtask

    task automatic model_cycle(input logic do_rsp);
        logic   exp_rv;
        fetch_t f;
        insn_t  e;
        exp_rv = !m_halted && !redirect_valid && ((m_fifo.size() + m_infl.size()) < DEPTH);
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        check("req_addr", 32'(imem_req_addr), 32'(m_pc));
        check("if_valid", 32'(if_valid), 32'(m_fifo.size() != 0));
        check("halted", 32'(halted), 32'(m_halted));
        if (m_fifo.size() != 0) begin
            check("if_ir", if_ir, m_fifo[0].ir);
            check("if_npc", if_npc, m_fifo[0].npc);
        end
        if (redirect_valid) begin
            if (do_rsp && m_infl.size() != 0) void'(m_infl.pop_front());
            foreach (m_infl[i]) m_infl[i].stale = 1'b1;
            m_fifo.delete();
            m_pc     = redirect_pc;
            m_halted = 1'b0;
        end else begin
            if (m_fifo.size() != 0 && if_ready) void'(m_fifo.pop_front());
            if (do_rsp && m_infl.size() != 0) begin
                f = m_infl.pop_front();
                if (!f.stale) begin
                    e.ir  = mem_word(f.addr);
                    e.npc = 32'(f.addr) + 32'd1;
                    m_fifo.push_back(e);
                    if (e.ir[31:26] == 6'b111111) m_halted = 1'b1;
                end
            end
            if (exp_rv && imem_req_ready) begin
                f.addr  = m_pc;
                f.stale = 1'b0;
                m_infl.push_back(f);
                m_pc = m_pc + ADDR_W'(1);
            end
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle();
        logic              do_rsp, acc_now;
        logic [ADDR_W-1:0] addr_now;
        mem_req_t          r;
        insn_t             g;
        do_rsp = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        imem_rsp_valid = do_rsp;
        imem_rsp_data  = do_rsp ? mem_word(mem_q[0].addr) : '0;
        #1;
        acc_now  = imem_req_valid && imem_req_ready;
        addr_now = imem_req_addr;
        if (acc_now) acc.push_back(addr_now);
        if (if_valid && if_ready && !redirect_valid) begin
            g.ir  = if_ir;
            g.npc = if_npc;
            got.push_back(g);
        end
        model_cycle(do_rsp);
        @(posedge clk1);
        if (do_rsp) void'(mem_q.pop_front());
        if (acc_now) begin
            r.addr = addr_now;
            r.due  = cyc + lat;
            mem_q.push_back(r);
        end
        cyc++;
        @(negedge clk1);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mem_q.delete();
        m_reset();
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", 32'(imem_req_addr), 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_ir", if_ir, 32'd0);
        check("rst_if_npc", if_npc, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        repeat (2) @(negedge clk1);
        rst_n = 1'b1;
        got.delete();
        acc.delete();
    endtask

    task automatic check_got(input string name, input int idx, input logic [31:0] ir,
                             input logic [31:0] npc);
        if (idx < got.size()) begin
            check({name, "_ir"}, got[idx].ir, ir);
            check({name, "_npc"}, got[idx].npc, npc);
        end else begin
            check({name, "_count"}, 32'(got.size()), 32'(idx + 1));
        end
    endtask

    task automatic check_acc(input string name, input int idx, input logic [31:0] addr);
        if (idx < acc.size()) check(name, 32'(acc[idx]), addr);
        else check({name, "_count"}, 32'(acc.size()), 32'(idx + 1));
    endtask

    initial begin
        int n0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        @(negedge clk1);

        // Streaming at latency 1: one instruction per cycle once filled.
        do_reset();
        lat = 1; hlt_en = 1'b0; if_ready = 1'b1; imem_req_ready = 1'b1;
        run(10);
        n0 = got.size();
        run(10);
        check("t1_throughput", 32'(got.size() - n0), 32'd10);
        check_got("t1_w0", 0, 32'h1000, 32'd1);
        check_got("t1_w1", 1, 32'h1001, 32'd2);
        check_got("t1_w2", 2, 32'h1002, 32'd3);

        // Decode stalled at latency 3: credit caps issue at DEPTH.
        do_reset();
        lat = 3; if_ready = 1'b0; imem_req_ready = 1'b1;
        run(12);
        check("t2_issued", 32'(acc.size()), 32'd4);
        check("t2_req_stalled", 32'(imem_req_valid), 32'd0);
        acc.delete();
        got.delete();
        if_ready = 1'b1;
        run(12);
        for (int i = 0; i < 4; i++) check_got("t2_drain", i, 32'h1000 + 32'(i), 32'(i + 1));
        check_acc("t2_restart_addr", 0, 32'd4);

        // Memory back-pressure alternating.
        do_reset();
        lat = 1; if_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            imem_req_ready = (i % 2 == 0);
            cycle();
        end
        imem_req_ready = 1'b1;
        check("t3_accept_count", 32'(acc.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_acc("t3_accept_addr", i, 32'(i));

        // Redirect with three fetches in flight, then back-to-back redirects.
        do_reset();
        lat = 3; if_ready = 1'b1; imem_req_ready = 1'b1;
        run(3);
        redirect_valid = 1'b1; redirect_pc = 10'h020;
        cycle();
        redirect_valid = 1'b0;
        run(15);
        check_got("t4_first_after_redirect", 0, 32'h1020, 32'h21);
        got.delete();
        redirect_valid = 1'b1; redirect_pc = 10'h030;
        cycle();
        redirect_pc = 10'h040;
        cycle();
        redirect_valid = 1'b0;
        run(15);
        check_got("t4_last_redirect_wins", 0, 32'h1040, 32'h41);

        // HLT at address 5, then redirect out of the halted state.
        do_reset();
        lat = 1; hlt_en = 1'b1; hlt_addr = 10'd5; if_ready = 1'b1; imem_req_ready = 1'b1;
        run(15);
        check("t5_halted", 32'(halted), 32'd1);
        check("t5_delivered", 32'(got.size()), 32'd7);
        check_got("t5_hlt_word", 5, 32'hFC00_0005, 32'd6);
        check("t5_requests", 32'(acc.size()), 32'd7);
        check_acc("t5_last_req", 6, 32'd6);
        got.delete();
        redirect_valid = 1'b1; redirect_pc = 10'h010;
        cycle();
        redirect_valid = 1'b0;
        check("t5_unhalted", 32'(halted), 32'd0);
        run(10);
        check_got("t5_resume", 0, 32'h1010, 32'h11);
        hlt_en = 1'b0;

        // Reset asserted with responses pending.
        do_reset();
        lat = 3; if_ready = 1'b1; imem_req_ready = 1'b1;
        run(5);
        do_reset();
        run(10);
        check_acc("t6_restart_addr", 0, 32'd0);
        check_got("t6_first_word", 0, 32'h1000, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
